adder_rr_sched: RTL

- Shares one pipelined W-bit adder core between two requesters.
- Round-robin arbiter issues at most one operation per cycle into the core.
- A tag pipeline tracks the owner of each in-flight operation, and each result is returned only to the requester that issued it.
- Sits between ALU operand sources (e.g. address-gen and execute) and the shared adder datapath.

---
 rtl/adder_sched_pkg.sv | 22 ++
 rtl/add_pipe.sv | 52 +++++
 rtl/adder_rr_sched.sv | 112 +++++++++++
 3 files changed

// File: rtl/adder_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adder_sched_pkg
//  Description : Shared types and constants for the round-robin adder scheduler
//  Revision    : 1.0 - initial release
// ============================================================================
package adder_sched_pkg;

    localparam int c_DEF_W   = 32;
    localparam int c_DEF_LAT = 3;

    localparam logic [1:0] OP_ADD  = 2'd0;
    localparam logic [1:0] OP_ADDC = 2'd1;
    localparam logic [1:0] OP_SUB  = 2'd2;

    typedef struct packed {
        logic valid;
        logic owner;
    } tag_t;

endpackage : adder_sched_pkg
`default_nettype wire

// File: rtl/add_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : add_pipe
//  Description : Three-stage W-bit adder split into two W/2 halves
//  Revision    : 1.0 - initial release
// ============================================================================
module add_pipe #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    localparam int c_H = W / 2;

    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic           r_cin;
    logic [c_H-1:0] r_lo_sum;
    logic           r_lo_c;
    logic [c_H-1:0] r_a_hi;
    logic [c_H-1:0] r_b_hi;
    logic [W-1:0]   r_sum;
    logic           r_cout;
    logic [c_H:0]   w_lo;
    logic [c_H:0]   w_hi;

    assign w_lo = {1'b0, r_a[c_H-1:0]} + {1'b0, r_b[c_H-1:0]} + {{c_H{1'b0}}, r_cin};
    assign w_hi = {1'b0, r_a_hi} + {1'b0, r_b_hi} + {{c_H{1'b0}}, r_lo_c};

    // Datapath only: no reset, validity is tracked by the scheduler's tags.
    always_ff @(posedge clk_i) begin
        r_a      <= a;
        r_b      <= b;
        r_cin    <= cin;
        r_lo_sum <= w_lo[c_H-1:0];
        r_lo_c   <= w_lo[c_H];
        r_a_hi   <= r_a[W-1:c_H];
        r_b_hi   <= r_b[W-1:c_H];
        r_sum    <= {w_hi[c_H-1:0], r_lo_sum};
        r_cout   <= w_hi[c_H];
    end

    assign sum  = r_sum;
    assign cout = r_cout;

endmodule : add_pipe
`default_nettype wire

// File: rtl/adder_rr_sched.sv
`default_nettype none
// ============================================================================
//  Module      : adder_rr_sched
//  Description : Round-robin sharing of one pipelined adder between two requesters
//  Revision    : 1.0 - initial release
// ============================================================================
module adder_rr_sched
    import adder_sched_pkg::*;
#(
    parameter int W   = c_DEF_W,
    parameter int LAT = c_DEF_LAT
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [1:0]                   req_valid_i,
    output logic [1:0]                   req_ready_o,
    input  logic [1:0][1:0]              req_op_i,
    input  logic [1:0][W-1:0]            req_a_i,
    input  logic [1:0][W-1:0]            req_b_i,
    input  logic [1:0]                   req_c_i,
    output logic [1:0]                   rsp_valid_o,
    output logic [W-1:0]                 rsp_sum_o,
    output logic                         rsp_cout_o,
    output logic                         busy_o,
    output logic [$clog2(LAT+1)-1:0]     inflight_o
);

    localparam int c_CW = $clog2(LAT + 1);

    logic                 r_rr_ptr;
    tag_t [LAT-1:0]       r_tag;
    logic                 w_issue;
    logic                 w_grant;
    logic [1:0]           w_op;
    logic [W-1:0]         w_a;
    logic [W-1:0]         w_b;
    logic                 w_cin;
    logic [W-1:0]         w_sum;
    logic                 w_cout;
    logic [c_CW-1:0]      w_inflight;

    always_comb begin
        w_grant = r_rr_ptr;
        case (req_valid_i)
            2'b01:   w_grant = 1'b0;
            2'b10:   w_grant = 1'b1;
            default: w_grant = r_rr_ptr;
        endcase
        w_issue = (|req_valid_i) & ~rst_i;

        w_op  = req_op_i[w_grant];
        w_a   = req_a_i[w_grant];
        w_b   = req_b_i[w_grant];
        w_cin = 1'b0;
        // Reserved encoding falls through to plain ADD.
        case (w_op)
            OP_ADD:  w_cin = 1'b0;
            OP_ADDC: w_cin = req_c_i[w_grant];
            OP_SUB: begin
                w_b   = ~req_b_i[w_grant];
                w_cin = 1'b1;
            end
            default: w_cin = 1'b0;
        endcase
    end

    assign req_ready_o = w_issue ? (w_grant ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rr_ptr <= 1'b0;
            r_tag    <= '0;
        end else begin
            if (w_issue) begin
                r_rr_ptr <= ~w_grant;
            end
            r_tag[0] <= tag_t'{valid: w_issue, owner: w_grant};
            for (int i = 1; i < LAT; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < LAT; i++) begin
            w_inflight = w_inflight + c_CW'(r_tag[i].valid);
        end
    end

    add_pipe #(
        .W (W)
    ) u_add_pipe (
        .clk_i (clk_i),
        .a     (w_a),
        .b     (w_b),
        .cin   (w_cin),
        .sum   (w_sum),
        .cout  (w_cout)
    );

    // Status outputs are forced idle for as long as reset is held.
    assign rsp_valid_o = rst_i ? 2'b00 :
                         {r_tag[LAT-1].valid &  r_tag[LAT-1].owner,
                          r_tag[LAT-1].valid & ~r_tag[LAT-1].owner};
    assign rsp_sum_o   = w_sum;
    assign rsp_cout_o  = w_cout;
    assign inflight_o  = rst_i ? '0 : w_inflight;
    assign busy_o      = ~rst_i & (w_inflight != '0);

endmodule : adder_rr_sched
`default_nettype wire
